// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave phase controller: FSM state encoding,
// command codes and bit-count helper.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DUMMY   = 3'd2,
        ST_DATA_RX = 3'd3,
        ST_DATA_TX = 3'd4,
        ST_HOLD    = 3'd5
    } phase_state_e;

    localparam logic [3:0] CMD_WRITE_MEM  = 4'd1;
    localparam logic [3:0] CMD_READ_MEM   = 4'd2;
    localparam logic [3:0] CMD_READ_REG0  = 4'd3;
    localparam logic [3:0] CMD_WRITE_REG0 = 4'd4;
    localparam logic [3:0] CMD_WRITE_REG1 = 4'd5;
    localparam logic [3:0] CMD_READ_REG1  = 4'd6;
    localparam logic [3:0] CMD_WRITE_REG2 = 4'd6;
    localparam logic [3:0] CMD_READ_REG2  = 4'd7;

    localparam logic [5:0] RX_CNT_CMD = 6'd7;

    function automatic logic [5:0] bits_m1(input int w);
        return 6'(w - 1);
    endfunction

endpackage

// File: rtl/spi_slave_dummy_cnt.sv
// Dummy-cycle down-counter: load a count, decrement while enabled, done flags
// the last counted cycle.
module spi_slave_dummy_cnt (
    input  logic       sclk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/spi_slave_phase_ctrl.sv
// SPI slave transaction phase controller (command, address, dummy, data, hold).
// Define SPI_SLAVE_ADDR_INC_EN to step addr by DATA_W/8 between continuous words.
module spi_slave_phase_ctrl
    import spi_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_done,
    input  logic [7:0]        dummy_cycles,
    output logic [3:0]        cmd,
    input  logic              get_addr,
    input  logic              get_data,
    input  logic              send_data,
    input  logic              enable_cont,
    input  logic              enable_regs,
    input  logic              wait_dummy,
    input  logic [1:0]        reg_sel,
    output logic [5:0]        rx_cnt,
    output logic              rx_cnt_upd,
    output logic              tx_en,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_req,
    output logic              rd_req,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [1:0]        reg_sel_o,
    output logic [2:0]        state_dbg
);

`ifdef SPI_SLAVE_ADDR_INC_EN
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
`endif

    // All request outputs are single-cycle registered pulses with no back-pressure;
    // addr is valid in the same cycle as wr_req/rd_req/reg_wr/reg_rd.
    phase_state_e      state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        reg_sel_q, reg_sel_d;
    logic [5:0]        rx_cnt_q, rx_cnt_d;
    logic              rx_cnt_upd_q, rx_cnt_upd_d;
    logic              tx_en_q, tx_en_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic              reg_wr_q, reg_wr_d;
    logic              reg_rd_q, reg_rd_d;
    logic              decode_q, decode_d;
    logic              post_rst_q;
    logic              load_dummy;
    logic              dummy_done;

    spi_slave_dummy_cnt u_dummy_cnt (
        .sclk     (sclk),
        .rst      (rst),
        .load     (load_dummy),
        .load_val (dummy_cycles),
        .en       (state_q == ST_DUMMY),
        .done     (dummy_done)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        reg_sel_d    = reg_sel_q;
        rx_cnt_d     = rx_cnt_q;
        rx_cnt_upd_d = post_rst_q;
        wr_req_d     = 1'b0;
        rd_req_d     = 1'b0;
        reg_wr_d     = 1'b0;
        reg_rd_d     = 1'b0;
        decode_d     = 1'b0;
        load_dummy   = 1'b0;

        if (cs_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Decoder outputs follow cmd_q, so branch one cycle after the latch.
                    if (decode_q) begin
                        reg_sel_d = reg_sel;
                        if (get_addr)       state_d = ST_ADDR;
                        else if (get_data)  state_d = ST_DATA_RX;
                        else if (send_data) state_d = ST_DATA_TX;
                        else                state_d = ST_HOLD;
                    end else if (rx_valid) begin
                        cmd_d    = rx_data[3:0];
                        decode_d = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_d = rx_data[ADDR_W-1:0];
                        if (wait_dummy) begin
                            if (dummy_cycles == 8'd0) begin
                                state_d = ST_DATA_TX;
                            end else begin
                                state_d    = ST_DUMMY;
                                load_dummy = 1'b1;
                            end
                        end else if (get_data) begin
                            state_d = ST_DATA_RX;
                        end else begin
                            state_d = ST_DATA_TX;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (dummy_done) state_d = ST_DATA_TX;
                end
                ST_DATA_RX: begin
`ifdef SPI_SLAVE_ADDR_INC_EN
                    // Step after the write pulse so it carries the address of its own word.
                    if ((wr_req_q || reg_wr_q) && enable_cont) addr_d = addr_q + ADDR_STEP;
`endif
                    if (rx_valid) begin
                        if (enable_regs) reg_wr_d = 1'b1;
                        else             wr_req_d = 1'b1;
                        if (!enable_cont) state_d = ST_HOLD;
                    end
                end
                ST_DATA_TX: begin
                    if (tx_done) begin
                        if (enable_cont) begin
`ifdef SPI_SLAVE_ADDR_INC_EN
                            addr_d = addr_q + ADDR_STEP;
`endif
                            if (enable_regs) reg_rd_d = 1'b1;
                            else             rd_req_d = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (state_d != state_q) begin
            case (state_d)
                ST_IDLE: begin
                    rx_cnt_upd_d = 1'b1;
                    rx_cnt_d     = RX_CNT_CMD;
                end
                ST_ADDR: begin
                    rx_cnt_upd_d = 1'b1;
                    rx_cnt_d     = bits_m1(ADDR_W);
                end
                ST_DATA_RX: begin
                    rx_cnt_upd_d = 1'b1;
                    rx_cnt_d     = bits_m1(DATA_W);
                end
                ST_DATA_TX: begin
                    if (enable_regs) reg_rd_d = 1'b1;
                    else             rd_req_d = 1'b1;
                end
                default: begin
                end
            endcase
        end

        tx_en_d = (state_d == ST_DATA_TX);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 4'd0;
            addr_q       <= '0;
            reg_sel_q    <= 2'd0;
            rx_cnt_q     <= RX_CNT_CMD;
            rx_cnt_upd_q <= 1'b0;
            tx_en_q      <= 1'b0;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            decode_q     <= 1'b0;
            post_rst_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            reg_sel_q    <= reg_sel_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_cnt_upd_q <= rx_cnt_upd_d;
            tx_en_q      <= tx_en_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            reg_wr_q     <= reg_wr_d;
            reg_rd_q     <= reg_rd_d;
            decode_q     <= decode_d;
            post_rst_q   <= 1'b0;
        end
    end

    assign cmd        = cmd_q;
    assign addr       = addr_q;
    assign reg_sel_o  = reg_sel_q;
    assign rx_cnt     = rx_cnt_q;
    assign rx_cnt_upd = rx_cnt_upd_q;
    assign tx_en      = tx_en_q;
    assign wr_req     = wr_req_q;
    assign rd_req     = rd_req_q;
    assign reg_wr     = reg_wr_q;
    assign reg_rd     = reg_rd_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_spi_slave_phase_ctrl.sv
// Bench for spi_slave_phase_ctrl: directed transactions push expected pulses
// (kind, cycle stamp, value) into a queue that a negedge monitor pops and compares.
module tb_spi_slave_phase_ctrl;
    import spi_slave_pkg::*;

`ifdef SPI_SLAVE_ADDR_INC_EN
    localparam logic [31:0] STEP = 32'd4;
`else
    localparam logic [31:0] STEP = 32'd0;
`endif
    localparam logic [2:0] K_UPD = 3'd1, K_WR = 3'd2, K_RD = 3'd3, K_RWR = 3'd4, K_RRD = 3'd5;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = 32'd0;
    logic        tx_done = 1'b0;
    logic [7:0]  dummy_cycles = 8'd0;
    logic        cont_mode = 1'b0;
    logic [3:0]  cmd;
    logic        get_addr, get_data, send_data, enable_cont, enable_regs, wait_dummy;
    logic [1:0]  reg_sel;
    logic [5:0]  rx_cnt;
    logic        rx_cnt_upd, tx_en, wr_req, rd_req, reg_wr, reg_rd;
    logic [31:0] addr;
    logic [1:0]  reg_sel_o;
    logic [2:0]  state_dbg;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [50:0] exp_q[$];

    spi_slave_phase_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .sclk(sclk), .rst(rst), .cs_n(cs_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_done(tx_done), .dummy_cycles(dummy_cycles), .cmd(cmd),
        .get_addr(get_addr), .get_data(get_data), .send_data(send_data),
        .enable_cont(enable_cont), .enable_regs(enable_regs), .wait_dummy(wait_dummy),
        .reg_sel(reg_sel), .rx_cnt(rx_cnt), .rx_cnt_upd(rx_cnt_upd), .tx_en(tx_en),
        .addr(addr), .wr_req(wr_req), .rd_req(rd_req), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_sel_o(reg_sel_o), .state_dbg(state_dbg)
    );

    // Reference command decoder (lives outside the DUT).
    always_comb begin
        get_addr    = 1'b0;
        get_data    = 1'b0;
        send_data   = 1'b0;
        enable_regs = 1'b0;
        wait_dummy  = 1'b0;
        reg_sel     = 2'd0;
        enable_cont = cont_mode;
        case (cmd)
            CMD_WRITE_MEM:  begin get_addr = 1'b1; get_data = 1'b1; end
            CMD_READ_MEM:   begin get_addr = 1'b1; send_data = 1'b1; wait_dummy = 1'b1; end
            CMD_READ_REG0:  begin send_data = 1'b1; enable_regs = 1'b1; end
            CMD_WRITE_REG0: begin get_data = 1'b1; enable_regs = 1'b1; end
            CMD_WRITE_REG1: begin get_data = 1'b1; enable_regs = 1'b1; reg_sel = 2'd1; end
            CMD_READ_REG2:  begin send_data = 1'b1; enable_regs = 1'b1; reg_sel = 2'd2; end
            default: begin end
        endcase
    end

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    function automatic logic [50:0] ev(input logic [2:0] k, input int stamp, input logic [31:0] v);
        return {k, 16'(stamp), v};
    endfunction

    task automatic push(input logic [2:0] k, input int stamp, input logic [31:0] v);
        exp_q.push_back(ev(k, stamp, v));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got(input string name, input logic [50:0] act);
        logic [50:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse kind=%0d stamp=%0d val=%h", name, act[50:48], act[47:32], act[31:0]);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                errors++;
                $display("FAIL %s: got kind=%0d stamp=%0d val=%h expected kind=%0d stamp=%0d val=%h",
                         name, act[50:48], act[47:32], act[31:0], e[50:48], e[47:32], e[31:0]);
            end
        end
    endtask

    // Monitor: each pulse seen is matched against the next expected event.
    always @(negedge sclk) begin
        if (rx_cnt_upd) got("rx_cnt_upd", ev(K_UPD, cyc, 32'(rx_cnt)));
        if (wr_req)     got("wr_req", ev(K_WR, cyc, addr));
        if (rd_req)     got("rd_req", ev(K_RD, cyc, addr));
        if (reg_wr)     got("reg_wr", ev(K_RWR, cyc, 32'(reg_sel_o)));
        if (reg_rd)     got("reg_rd", ev(K_RRD, cyc, 32'(reg_sel_o)));
    end

    task automatic rxw(input logic [31:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge sclk);
        rx_valid = 1'b0;
        repeat (2) @(negedge sclk);
    endtask

    task automatic txd;
        tx_done = 1'b1;
        @(negedge sclk);
        tx_done = 1'b0;
        repeat (2) @(negedge sclk);
    endtask

    task automatic cs_start(input logic c);
        cont_mode = c;
        cs_n = 1'b0;
        @(negedge sclk);
    endtask

    task automatic cs_end;
        push(K_UPD, cyc + 1, 32'd7);
        cs_n = 1'b1;
        @(negedge sclk);
        chk("idle_after_cs", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge sclk);
    endtask

    task automatic mem_write_hdr(input logic [31:0] a);
        int t;
        t = cyc + 1;
        push(K_UPD, t + 1, 32'd31);
        rxw(32'(CMD_WRITE_MEM));
        t = cyc + 1;
        push(K_UPD, t, 32'd31);
        rxw(a);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge sclk);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_reg_sel_o", 32'(reg_sel_o), 32'd0);
        chk("rst_rx_cnt", 32'(rx_cnt), 32'd7);
        chk("rst_outs", 32'({rx_cnt_upd, wr_req, rd_req, reg_wr, reg_rd, tx_en}), 32'd0);
        push(K_UPD, cyc + 1, 32'd7);
        rst = 1'b0;
        repeat (2) @(negedge sclk);

        // Continuous memory write, three words.
        cs_start(1'b1);
        mem_write_hdr(32'h0000_1000);
        for (int i = 0; i < 3; i++) begin
            t = cyc + 1;
            push(K_WR, t, 32'h0000_1000 + 32'(i) * STEP);
            rxw(32'hA000_0000 + 32'(i));
        end
        cs_end();
        chk("t1_addr_retained", addr, 32'h0000_1000 + 3 * STEP);

        // Memory read with 32 dummy cycles.
        cs_start(1'b0);
        dummy_cycles = 8'd32;
        t = cyc + 1;
        push(K_UPD, t + 1, 32'd31);
        rxw(32'(CMD_READ_MEM));
        t = cyc + 1;
        push(K_RD, t + 32, 32'h0000_0020);
        rxw(32'h0000_0020);
        repeat (8) @(negedge sclk);
        chk("dummy_state", 32'(state_dbg), 32'(ST_DUMMY));
        chk("dummy_tx_en", 32'(tx_en), 32'd0);
        for (int i = 0; i < 64 && cyc < t + 32; i++) @(negedge sclk);
        chk("rd_state", 32'(state_dbg), 32'(ST_DATA_TX));
        chk("rd_tx_en", 32'(tx_en), 32'd1);
        txd();
        chk("rd_hold", 32'(state_dbg), 32'(ST_HOLD));
        chk("rd_hold_tx_en", 32'(tx_en), 32'd0);
        cs_end();

        // Memory read, zero dummy cycles, continuous.
        cs_start(1'b1);
        dummy_cycles = 8'd0;
        t = cyc + 1;
        push(K_UPD, t + 1, 32'd31);
        rxw(32'(CMD_READ_MEM));
        t = cyc + 1;
        push(K_RD, t, 32'h0000_0040);
        rxw(32'h0000_0040);
        chk("rd0_tx_en", 32'(tx_en), 32'd1);
        t = cyc + 1;
        push(K_RD, t, 32'h0000_0040 + STEP);
        txd();
        cs_end();

        // Register write 0, then extra words ignored in HOLD.
        cs_start(1'b0);
        t = cyc + 1;
        push(K_UPD, t + 1, 32'd31);
        rxw(32'(CMD_WRITE_REG0));
        t = cyc + 1;
        push(K_RWR, t, 32'd0);
        rxw(32'hDEAD_BEEF);
        chk("reg0_hold", 32'(state_dbg), 32'(ST_HOLD));
        rxw(32'h1234_5678);
        txd();
        chk("reg0_still_hold", 32'(state_dbg), 32'(ST_HOLD));
        cs_end();

        // Register write 1: reg_sel_o latched as 1.
        cs_start(1'b0);
        t = cyc + 1;
        push(K_UPD, t + 1, 32'd31);
        rxw(32'(CMD_WRITE_REG1));
        t = cyc + 1;
        push(K_RWR, t, 32'd1);
        rxw(32'h0000_00AA);
        cs_end();
        chk("reg1_sel_retained", 32'(reg_sel_o), 32'd1);

        // Register read 2: reg_rd on DATA_TX entry.
        cs_start(1'b0);
        t = cyc + 1;
        push(K_RRD, t + 1, 32'd2);
        rxw(32'(CMD_READ_REG2));
        chk("rreg2_state", 32'(state_dbg), 32'(ST_DATA_TX));
        txd();
        chk("rreg2_hold", 32'(state_dbg), 32'(ST_HOLD));
        cs_end();

        // Unknown command goes to HOLD silently.
        cs_start(1'b0);
        rxw(32'h0000_000F);
        chk("cmdf_hold", 32'(state_dbg), 32'(ST_HOLD));
        chk("cmdf_cmd", 32'(cmd), 32'h0000_000F);
        cs_end();

        // cs_n rise coincident with a data word: no write.
        cs_start(1'b1);
        mem_write_hdr(32'h0000_3000);
        push(K_UPD, cyc + 1, 32'd7);
        cs_n = 1'b1;
        rx_valid = 1'b1;
        rx_data = 32'h5555_AAAA;
        @(negedge sclk);
        rx_valid = 1'b0;
        chk("cs_abort_idle", 32'(state_dbg), 32'(ST_IDLE));
        repeat (2) @(negedge sclk);

        // Address wrap on continuous write.
        cs_start(1'b1);
        mem_write_hdr(32'hFFFF_FFFC);
        t = cyc + 1;
        push(K_WR, t, 32'hFFFF_FFFC);
        rxw(32'h0000_0001);
        t = cyc + 1;
        push(K_WR, t, 32'hFFFF_FFFC + STEP);
        rxw(32'h0000_0002);
        cs_end();

        // Reset mid-transfer overrides a pending data word.
        cs_start(1'b1);
        mem_write_hdr(32'h0000_5000);
        rst = 1'b1;
        rx_valid = 1'b1;
        @(negedge sclk);
        rx_valid = 1'b0;
        chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("mid_rst_addr", addr, 32'd0);
        chk("mid_rst_cmd", 32'(cmd), 32'd0);
        push(K_UPD, cyc + 1, 32'd7);
        rst = 1'b0;
        repeat (4) @(negedge sclk);

        while (exp_q.size() > 0) begin
            logic [50:0] e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: expected kind=%0d stamp=%0d val=%h never seen", e[50:48], e[47:32], e[31:0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_phase_ctrl.md
SPI_SLAVE_PHASE_CTRL -- requirements
Module: spi_slave_phase_ctrl

Interface
REQ-001 SHALL have parameters ADDR_W (default 32, address width) and DATA_W (default 32, data word width; addr step = DATA_W/8).
REQ-002 SHALL have ports: sclk  in  1  SPI clock; all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: cs_n  in  1  chip select, active-low; rx_valid  in  1  word received pulse; rx_data  in  DATA_W  received word (right-aligned).
REQ-005 SHALL have ports: tx_done  in  1  TX word shifted out pulse; dummy_cycles  in  8  dummy bit count.
REQ-006 SHALL have ports: cmd  out  4  to command decoder; get_addr, get_data, send_data, enable_cont, enable_regs, wait_dummy  in  1 each; reg_sel  in  2  (decoder outputs, combinational from cmd).
REQ-007 SHALL have ports: rx_cnt  out  6  expected bits-1 for RX shifter; rx_cnt_upd  out  1  load pulse for rx_cnt; tx_en  out  1  TX shifter enable.
REQ-008 SHALL have ports: addr  out  ADDR_W  current address; wr_req  out  1  memory write pulse; rd_req  out  1  memory read pulse.
REQ-009 SHALL have ports: reg_wr  out  1  register write pulse; reg_rd  out  1  register read pulse; reg_sel_o  out  2  registered reg_sel.

Function
REQ-010 SHALL implement FSM states IDLE, ADDR, DUMMY, DATA_RX, DATA_TX, HOLD.
REQ-011 SHALL, in IDLE, on rx_valid latch cmd = rx_data[3:0] and on the next cycle branch on decoder outputs: get_addr->ADDR, else get_data->DATA_RX, else send_data->DATA_TX, else HOLD.
REQ-012 SHALL pulse rx_cnt_upd for one cycle on every state entry with rx_cnt = 7 (IDLE), ADDR_W-1 (ADDR), DATA_W-1 (DATA_RX); no update in DUMMY/DATA_TX/HOLD.
REQ-013 SHALL, in ADDR, on rx_valid load addr = rx_data[ADDR_W-1:0], then go to DUMMY if wait_dummy, else DATA_RX if get_data, else DATA_TX.
REQ-014 SHALL, in DUMMY, count dummy_cycles sclk cycles then enter DATA_TX; dummy_cycles = 0 enters DATA_TX the cycle after ADDR completes.
REQ-015 SHALL, in DATA_RX, on rx_valid pulse reg_wr (enable_regs=1) or wr_req (enable_regs=0) for exactly one cycle, concurrent with addr of that word.
REQ-016 SHALL, on entry to DATA_TX, pulse reg_rd or rd_req once and hold tx_en=1 while in DATA_TX.
REQ-017 SHALL, on tx_done/rx_valid completion in a data state, stay in the state and advance addr when enable_cont=1, else go to HOLD.
REQ-018 SHALL, in continuous DATA_TX, pulse rd_req again in the cycle after each tx_done.
REQ-019 SHALL wrap addr modulo 2^ADDR_W on increment.
REQ-020 SHALL remain in HOLD, ignoring rx_valid/tx_done, until cs_n=1.
REQ-021 SHALL, when cs_n=1 in any cycle, go to IDLE next cycle and suppress all pulses that cycle; cs_n=1 takes priority over simultaneous rx_valid/tx_done.
REQ-022 SHALL pulse rx_cnt_upd (rx_cnt=7) on IDLE entry caused by cs_n.
REQ-023 SHALL keep reg_sel_o = reg_sel latched with cmd; addr and cmd retained across transactions until overwritten.

Reset
REQ-024 SHALL on rst=1 set state IDLE, cmd=0, addr=0, reg_sel_o=0, rx_cnt=7, all pulses and tx_en 0; rst overrides cs_n and mid-transfer activity.
REQ-025 SHALL pulse rx_cnt_upd in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, when SPI_SLAVE_ADDR_INC_EN is defined, increment addr by DATA_W/8 after each continuous word (REQ-017).
REQ-027 SHALL, when SPI_SLAVE_ADDR_INC_EN is undefined, hold addr constant for all words of a transaction (FIFO-style target).

Structure
REQ-028 SHALL place the FSM state enum and command code constants (write_mem=1, read_mem=2, read_reg0=3, write_reg0=4, write_reg1=5, read_reg1/write_reg2=6, read_reg2=7) in shared package spi_slave_pkg.
REQ-029 SHALL instantiate spi_slave_dummy_cnt (8-bit down-counter, load/done) as its only sub-module; decoder instantiated outside.

Verification
REQ-030 SHALL test cmd=1, addr=0x1000, 3 words, cont -> wr_req x3 at addr 0x1000/0x1004/0x1008 (0x1000 x3 without macro).
REQ-031 SHALL test cmd=2, addr=0x20, dummy_cycles=32 -> rd_req exactly 32 cycles after address rx_valid+1, tx_en high.
REQ-032 SHALL test cmd=4 data 0xDEADBEEF -> single reg_wr, reg_sel_o=0, then HOLD; further rx_valid ignored.
REQ-033 SHALL test cmd=0xF -> HOLD, no pulses; cs_n=1 -> IDLE, rx_cnt_upd with rx_cnt=7.
REQ-034 SHALL test cs_n=1 coincident with data rx_valid -> no wr_req, IDLE next cycle.
REQ-035 SHALL test addr=0xFFFFFFFC cont write, 2 words -> second wr_req at addr 0x00000000.
